hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32IM core. It drives the stall and flush controls of the F/D, D/E and E/M pipeline registers and produces the E-stage forwarding selects. It also sequences multi-cycle M-extension operations, holding the front of the pipeline while the multiply/divide unit iterates. Decisions are combinational from stage-tagged register fields, except the M-op sequencer, which is a small FSM with a down-counter.

## Interface
Parameters:
- RF_WIDTH, 5: register-index width.
- MUL_LAT, 2: cycles a multiply occupies E, ≥1.
- DIV_LAT, 33: cycles a divide/remainder occupies E, ≥1.

Ports:
- clk, in, 1: single clock; all state updates on posedge.
- rst, in, 1: synchronous, active-high reset.
- rs1D, rs2D, in, RF_WIDTH: source registers of the instruction in D.
- rs1E, rs2E, rdE, in, RF_WIDTH: source and destination registers of the instruction in E.
- rdM, rdW, in, RF_WIDTH: destination registers in M and W.
- regWriteM, regWriteW, in, 1: the M or W instruction writes rd.
- loadE, in, 1: the E instruction is a load.
- pcSrcE, in, 1: a taken branch or jump is resolved in E.
- muldivE, in, 1: the E instruction is an M-extension op.
- isDivE, in, 1: that op is DIV/DIVU/REM/REMU.
- stallF, stallD, stallE, out, 1: hold the PC, F/D and D/E registers.
- flushD, flushE, flushM, out, 1: zero the F/D, D/E and E/M registers.
- forwardAE, forwardBE, out, 2: operand select for E.
- mdStart, out, 1: one-cycle start pulse to the M unit.
- mdDone, out, 1: M unit result is valid this cycle.

## Operation
Forwarding (per operand; shown for A, B identical with rs2E):
- 2'b10 if regWriteM && rdM!=0 && rdM==rs1E.
- Otherwise 2'b01 if regWriteW && rdW!=0 && rdW==rs1E.
- Otherwise 2'b00. M takes priority over W.

Load-use hazard: lwStall = loadE && rdE!=0 && (rdE==rs1D || rdE==rs2D).

M-op sequencer, states IDLE and BUSY. Counter cnt is $clog2(DIV_LAT) bits wide. The selected latency is lat = isDivE ? DIV_LAT : MUL_LAT.
- In IDLE with muldivE:
  - mdStart=1 for one cycle.
  - If lat==1: mdDone=1 in the same cycle and there is no stall.
  - Otherwise: mdStall=1, cnt<=lat-2, next state BUSY.
- In BUSY:
  - While cnt!=0: mdStall=1 and cnt decrements.
  - When cnt==0: mdStall=0, mdDone=1, next state IDLE.
- The M-op spends exactly lat cycles in E, of which lat-1 are stalled.

Output equations:
- stallF = stallD = lwStall || mdStall.
- stallE = mdStall.
- flushM = mdStall (a bubble enters M while E is held).
- flushD = pcSrcE.
- flushE = (lwStall || pcSrcE) && !mdStall.

Priorities and boundary cases:
- pcSrcE together with lwStall: both flushes assert and the branch wins. The PC reloads because the PC mux overrides stallF; the wrong-path load-use stall is harmless.
- mdStall suppresses flushE, so an M-op in E is never killed.
- pcSrcE and muldivE cannot both be true; they come from the same E instruction.
- Back-to-back M-ops: the first one's mdDone cycle returns the FSM to IDLE. The next op is seen in IDLE one cycle later, so the FSM never retriggers on the same instruction.

## Timing
- Forwarding, lwStall and flushes are combinational, with zero latency.
- mdStall and mdStart are Mealy in IDLE (same cycle muldivE rises) and Moore in BUSY.
- Reset:
  - state<=IDLE, cnt<=0.
  - Given idle inputs, every output is 0 and forwardAE/BE are 2'b00.
- Reset asserted mid-BUSY: IDLE on the next edge, the stall drops, no mdDone pulse.
- Counter wrap is impossible: BUSY exits at cnt==0 before any decrement.

## Structure
- Shared package rv_pkg holds:
  - the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the md_state_t enum {MD_IDLE, MD_BUSY}.
- Sub-module md_seq holds the FSM and counter. Inputs: clk, rst, muldivE, isDivE. Outputs: mdStall, mdStart, mdDone.
- The top level holds the forwarding and stall/flush combining logic.

## Test plan
- Forwarding: rdM=5, regWriteM=1, rdW=5, regWriteW=1, rs1E=5, rs2E=0 -> forwardAE=2'b10, forwardBE=2'b00. Same stimulus with rdM=0 -> forwardAE=2'b01.
- Load-use: loadE=1, rdE=7, rs2D=7 -> stallF=stallD=1, flushE=1, stallE=0 for exactly one cycle. rdE=0 -> no stall.
- Branch: pcSrcE=1 with the load-use condition also true -> flushD=1 and flushE=1.
- Divide: muldivE=isDivE=1 for the held instruction, DIV_LAT=33:
  - mdStart pulses in cycle 0;
  - stallF/D/E and flushM are high for cycles 0..31;
  - mdDone=1 with all stalls low in cycle 32;
  - flushE stays 0 throughout.
- Multiply with MUL_LAT=1 -> mdStart=mdDone=1 in the same cycle, no stall. Then two back-to-back divides -> two separate 32-cycle stall windows, each followed by its mdDone.
- Reset mid-operation: assert rst at cycle 10 of a divide -> all stalls 0 on the next cycle, no mdDone. A later muldivE starts a fresh full-length sequence.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared constants and types for the RV32IM hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// ============================================================================
// Module      : md_seq
// Description : Multi-cycle M-extension sequencer; stalls the front end for
//               lat-1 cycles and flags the cycle the result is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module md_seq
  import rv_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic muldivE,
  input  logic isDivE,
  output logic mdStall,
  output logic mdStart,
  output logic mdDone
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_lat_one;
  logic [CNT_W-1:0] w_cnt_load;

  assign w_lat_one  = isDivE ? (DIV_LAT == 1) : (MUL_LAT == 1);
  assign w_cnt_load = isDivE ? DIV_CNT0 : MUL_CNT0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // BUSY exits at cnt==0 before decrementing, so the counter never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mdStall     = 1'b0;
    mdStart     = 1'b0;
    mdDone      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (muldivE) begin
          mdStart = 1'b1;
          if (w_lat_one) begin
            mdDone = 1'b1;
          end else begin
            mdStall     = 1'b1;
            w_cnt_nxt   = w_cnt_load;
            w_state_nxt = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (r_cnt != '0) begin
          mdStall   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          mdDone      = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush control and E-stage forwarding for the 5-stage
//               RV32IM pipeline, including M-op sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import rv_pkg::*;
#(
  parameter int RF_WIDTH = 5,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RF_WIDTH-1:0] rs1D,
  input  logic [RF_WIDTH-1:0] rs2D,
  input  logic [RF_WIDTH-1:0] rs1E,
  input  logic [RF_WIDTH-1:0] rs2E,
  input  logic [RF_WIDTH-1:0] rdE,
  input  logic [RF_WIDTH-1:0] rdM,
  input  logic [RF_WIDTH-1:0] rdW,
  input  logic                regWriteM,
  input  logic                regWriteW,
  input  logic                loadE,
  input  logic                pcSrcE,
  input  logic                muldivE,
  input  logic                isDivE,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                flushD,
  output logic                flushE,
  output logic                flushM,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                mdStart,
  output logic                mdDone
);

  logic w_lw_stall;
  logic w_md_stall;

  function automatic logic [1:0] fwd_sel(input logic [RF_WIDTH-1:0] rs);
    if (regWriteM && (rdM != '0) && (rdM == rs))
      return FWD_MEM;
    else if (regWriteW && (rdW != '0) && (rdW == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  md_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .muldivE (muldivE),
    .isDivE  (isDivE),
    .mdStall (w_md_stall),
    .mdStart (mdStart),
    .mdDone  (mdDone)
  );

  assign forwardAE  = fwd_sel(rs1E);
  assign forwardBE  = fwd_sel(rs2E);
  assign w_lw_stall = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  // A held M-op must never be flushed out of E, so mdStall masks flushE.
  assign stallF = w_lw_stall || w_md_stall;
  assign stallD = w_lw_stall || w_md_stall;
  assign stallE = w_md_stall;
  assign flushM = w_md_stall;
  assign flushD = pcSrcE;
  assign flushE = (w_lw_stall || pcSrcE) && !w_md_stall;

endmodule
`default_nettype wire
